// File: rtl/instr_encoder.sv
// rtl/instr_encoder.sv - WISC 16-bit instruction field packer with range check and preload addressing
module instr_encoder #(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        in_opcode,
    input  logic [2:0]        in_rs,
    input  logic [2:0]        in_rt,
    input  logic [2:0]        in_rd,
    input  logic [1:0]        in_func,
    input  logic [15:0]       in_imm,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [15:0]       out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              err_valid,
    output logic [1:0]        err_code,
    input  logic              restart,
    output logic              done
);

    typedef enum logic [1:0] {IDLE, HOLD, DONE} state_t;

    state_t      state;
    logic [15:0] enc_word;
    logic        illegal;
    logic        range_bad;
    logic        accept;
    logic        drain;

    // Signed fit means every bit above the field equals the field MSB.
    logic fit_s11, fit_s8, fit_s5, fit_z8, fit_z5;
    assign fit_s11 = (&in_imm[15:10]) || !(|in_imm[15:10]);
    assign fit_s8  = (&in_imm[15:7])  || !(|in_imm[15:7]);
    assign fit_s5  = (&in_imm[15:4])  || !(|in_imm[15:4]);
    assign fit_z8  = !(|in_imm[15:8]);
    assign fit_z5  = !(|in_imm[15:5]);

    always_comb begin
        enc_word  = '0;
        illegal   = 1'b0;
        range_bad = 1'b0;
        case (in_opcode)
            5'b00000, 5'b00001: enc_word = {in_opcode, 11'b0};
            5'b00100, 5'b00110: begin
                enc_word  = {in_opcode, in_imm[10:0]};
                range_bad = !fit_s11;
            end
            5'b01000, 5'b01001, 5'b10000, 5'b10001, 5'b10011: begin
                enc_word  = {in_opcode, in_rs, in_rd, in_imm[4:0]};
                range_bad = !fit_s5;
            end
            5'b01010, 5'b01011, 5'b10100, 5'b10101, 5'b10110, 5'b10111: begin
                enc_word  = {in_opcode, in_rs, in_rd, in_imm[4:0]};
                range_bad = !fit_z5;
            end
            5'b11000, 5'b00101, 5'b00111,
            5'b01100, 5'b01101, 5'b01110, 5'b01111: begin
                enc_word  = {in_opcode, in_rs, in_imm[7:0]};
                range_bad = !fit_s8;
            end
            5'b10010: begin
                enc_word  = {in_opcode, in_rs, in_imm[7:0]};
                range_bad = !fit_z8;
            end
            5'b11001:           enc_word = {in_opcode, in_rs, 3'b000, in_rd, 2'b00};
            5'b11010, 5'b11011: enc_word = {in_opcode, in_rs, in_rt, in_rd, in_func};
            5'b11100, 5'b11101, 5'b11110, 5'b11111:
                                enc_word = {in_opcode, in_rs, in_rt, in_rd, 2'b00};
            default:            illegal = 1'b1;
        endcase
    end

    assign in_ready = (state != DONE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign drain    = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_addr  <= '0;
            err_valid <= 1'b0;
            err_code  <= 2'b00;
            done      <= 1'b0;
        end else begin
            err_valid <= 1'b0;
            if (state == DONE) begin
                if (restart) begin
                    state    <= IDLE;
                    done     <= 1'b0;
                    out_addr <= '0;
                end
            end else begin
                if (drain)
                    out_addr <= out_addr + ADDR_W'(2);
                // A drained HALT word (the only encoding equal to zero) ends the stream.
                if (drain && out_data == 16'h0000) begin
                    state     <= DONE;
                    out_valid <= 1'b0;
                    done      <= 1'b1;
                end else if (accept && !illegal && !range_bad) begin
                    out_data  <= enc_word;
                    out_valid <= 1'b1;
                    state     <= HOLD;
                end else if (drain) begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
                if (accept && (illegal || range_bad)) begin
                    err_valid <= 1'b1;
                    err_code  <= illegal ? 2'b01 : 2'b10;
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// tb/tb_instr_encoder.sv - randomized and directed bench for instr_encoder against a field-rule model
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready, in_ready4;
    logic [4:0]  in_opcode;
    logic [2:0]  in_rs, in_rt, in_rd;
    logic [1:0]  in_func;
    logic [15:0] in_imm;
    logic        out_valid, out_valid4;
    logic        out_ready;
    logic [15:0] out_data, out_data4;
    logic [15:0] out_addr;
    logic [3:0]  out_addr4;
    logic        err_valid, err_valid4;
    logic [1:0]  err_code, err_code4;
    logic        restart;
    logic        done, done4;

    always #5 clk = ~clk;

    instr_encoder #(.ADDR_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .in_func(in_func), .in_imm(in_imm), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_addr(out_addr),
        .err_valid(err_valid), .err_code(err_code), .restart(restart), .done(done)
    );

    // Narrow-address copy sees the same stimulus; only its wrapping address differs.
    instr_encoder #(.ADDR_W(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
        .in_opcode(in_opcode), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
        .in_func(in_func), .in_imm(in_imm), .out_valid(out_valid4),
        .out_ready(out_ready), .out_data(out_data4), .out_addr(out_addr4),
        .err_valid(err_valid4), .err_code(err_code4), .restart(restart), .done(done4)
    );

    int          total = 0;
    int          bad = 0;
    logic [15:0] q[$];
    int          addr_m = 0;
    bit          done_m = 0;
    logic [1:0]  code_m = 2'b00;
    bit          err_pend = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_enc(input logic [4:0] op, input logic [2:0] rs, input logic [2:0] rt,
                                      input logic [2:0] rd, input logic [1:0] fn, input logic [15:0] imm,
                                      output logic [15:0] w, output logic [1:0] err);
        int base = int'(op) * 2048;
        int u = int'(imm);
        int v = int'($signed(imm));
        int width = 0;
        bit zx = 0;
        int word = 0;
        err = 2'b00;
        case (int'(op)) inside
            0, 1:                 word = base;
            4, 6:                 begin width = 11; word = base + u % 2048; end
            8, 9, 16, 17, 19:     begin width = 5; word = base + rs * 256 + rd * 32 + u % 32; end
            10, 11, [20:23]:      begin width = 5; zx = 1; word = base + rs * 256 + rd * 32 + u % 32; end
            24, 5, 7, [12:15]:    begin width = 8; word = base + rs * 256 + u % 256; end
            18:                   begin width = 8; zx = 1; word = base + rs * 256 + u % 256; end
            25:                   word = base + rs * 256 + rd * 4;
            26, 27:               word = base + rs * 256 + rt * 32 + rd * 4 + fn;
            [28:31]:              word = base + rs * 256 + rt * 32 + rd * 4;
            default:              err = 2'b01;
        endcase
        if (err == 2'b00 && width != 0) begin
            if (zx ? (u >= (1 << width)) : (v < -(1 << (width - 1)) || v >= (1 << (width - 1))))
                err = 2'b10;
        end
        w = 16'(word);
    endfunction

    task automatic step(input bit rst, input bit v, input logic [4:0] op, input logic [2:0] rs,
                        input logic [2:0] rt, input logic [2:0] rd, input logic [1:0] fn,
                        input logic [15:0] imm, input bit ordy, input bit rs_t);
        logic [15:0] w;
        logic [1:0]  e;
        bit          exp_rdy;
        rst_n = !rst; in_valid = v; in_opcode = op; in_rs = rs; in_rt = rt; in_rd = rd;
        in_func = fn; in_imm = imm; out_ready = ordy; restart = rs_t;
        #1;
        if (rst) begin
            q.delete(); addr_m = 0; done_m = 0; code_m = 2'b00; err_pend = 0;
        end else begin
            exp_rdy = !done_m && (q.size() == 0 || ordy);
            chk("in_ready", 32'(in_ready), 32'(exp_rdy));
            chk("in_ready4", 32'(in_ready4), 32'(exp_rdy));
            err_pend = 0;
            if (done_m) begin
                if (rs_t) begin done_m = 0; addr_m = 0; end
            end else begin
                if (q.size() != 0 && ordy) begin
                    w = q.pop_front();
                    addr_m = (addr_m + 2) % 65536;
                    if (w == 16'h0000) done_m = 1;
                end
                if (v && exp_rdy) begin
                    model_enc(op, rs, rt, rd, fn, imm, w, e);
                    if (e != 2'b00) begin err_pend = 1; code_m = e; end
                    else q.push_back(w);
                end
            end
        end
        @(negedge clk);
        chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
        if (q.size() != 0) chk("out_data", 32'(out_data), 32'(q[0]));
        chk("out_addr", 32'(out_addr), 32'(addr_m));
        chk("out_addr4", 32'(out_addr4), 32'(addr_m % 16));
        chk("err_valid", 32'(err_valid), 32'(err_pend));
        chk("err_code", 32'(err_code), 32'(code_m));
        chk("done", 32'(done), 32'(done_m));
    endtask

    task automatic idle(input bit ordy);
        step(0, 0, 5'd0, 3'd0, 3'd0, 3'd0, 2'd0, 16'h0, ordy, 0);
    endtask

    initial begin
        logic [4:0]  rop;
        logic [15:0] rimm;
        @(negedge clk);
        step(1, 0, 5'd0, 3'd0, 3'd0, 3'd0, 2'd0, 16'h0, 0, 0);
        step(1, 0, 5'd0, 3'd0, 3'd0, 3'd0, 2'd0, 16'h0, 0, 0);
        chk("rst_data", 32'(out_data), 32'h0);

        step(0, 1, 5'b01000, 3'd1, 3'd0, 3'd2, 2'd0, 16'hFFFD, 1, 0);
        chk("addi_word", 32'(out_data), 32'h415D);
        chk("addi_addr", 32'(out_addr), 32'h0);
        step(0, 1, 5'b11011, 3'd3, 3'd4, 3'd5, 2'd0, 16'h0, 1, 0);
        chk("add_word", 32'(out_data), 32'hDB94);
        chk("add_addr", 32'(out_addr), 32'h2);

        step(0, 1, 5'b01010, 3'd1, 3'd0, 3'd1, 2'd0, 16'd32, 1, 0);
        chk("xori_err", 32'({err_valid, err_code}), 32'b110);
        step(0, 1, 5'b01000, 3'd1, 3'd0, 3'd1, 2'd0, 16'd16, 1, 0);
        chk("addi16_err", 32'({err_valid, err_code}), 32'b110);
        step(0, 1, 5'b01000, 3'd0, 3'd0, 3'd0, 2'd0, 16'hFFF0, 1, 0);
        chk("addi_m16", 32'(out_data), 32'h4010);
        step(0, 1, 5'b00010, 3'd0, 3'd0, 3'd0, 2'd0, 16'h0, 1, 0);
        chk("illegal_err", 32'({err_valid, err_code}), 32'b101);

        step(0, 1, 5'b01001, 3'd6, 3'd0, 3'd7, 2'd0, 16'h0003, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 5'b11101, 3'd2, 3'd3, 3'd4, 2'd3, 16'h0, 0, 0);
            chk("bp_data", 32'(out_data), 32'h4EE3);
            chk("bp_ready", 32'(in_ready), 32'h0);
        end
        step(0, 1, 5'b11101, 3'd2, 3'd3, 3'd4, 2'd3, 16'h0, 1, 0);
        chk("b2b_data", 32'(out_data), 32'hEA70);

        step(0, 1, 5'b00000, 3'd0, 3'd0, 3'd0, 2'd0, 16'h1234, 1, 0);
        idle(1);
        chk("halt_done", 32'(done), 32'h1);
        step(0, 1, 5'b00001, 3'd0, 3'd0, 3'd0, 2'd0, 16'h0, 1, 0);
        step(0, 0, 5'd0, 3'd0, 3'd0, 3'd0, 2'd0, 16'h0, 1, 1);
        chk("restart_done", 32'(done), 32'h0);

        for (int i = 0; i < 9; i++)
            step(0, 1, 5'b00001, 3'd0, 3'd0, 3'd0, 2'd0, 16'h0, 1, 0);
        chk("wrap_addr4", 32'(out_addr4), 32'h0);
        idle(1);

        for (int i = 0; i < 400; i++) begin
            rop = 5'($urandom);
            if (rop == 5'd0) rop = 5'd1;
            rimm = ($urandom_range(0, 3) == 0) ? 16'($urandom)
                                               : 16'(int'($urandom_range(0, 600)) - 300);
            step(0, bit'($urandom_range(0, 3) != 0), rop, 3'($urandom), 3'($urandom), 3'($urandom),
                 2'($urandom), rimm, bit'($urandom_range(0, 2) != 0), 0);
        end

        step(0, 1, 5'b10001, 3'd1, 3'd0, 3'd2, 2'd0, 16'h0004, 0, 0);
        idle(0);
        step(1, 0, 5'd0, 3'd0, 3'd0, 3'd0, 2'd0, 16'h0, 0, 0);
        chk("rst_hold_valid", 32'(out_valid), 32'h0);
        chk("rst_hold_addr", 32'(out_addr), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
